// File: rtl/hand_dealer.sv
// Sequential card source for the Baccarat datapath: free-running card counter,
// IDLE/WRITE/ACK dealing FSM and two three-slot hands. Optional: HAND_SCORE_EN.
module hand_dealer #(
  parameter int DECK_MAX = 13
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       deal_req,
  input  logic       target,
  input  logic       clear,
  output logic       busy,
  output logic       done,
  output logic       overflow,
  output logic [3:0] pcard1,
  output logic [3:0] pcard2,
  output logic [3:0] pcard3,
  output logic [3:0] dcard1,
  output logic [3:0] dcard2,
  output logic [3:0] dcard3,
  output logic [1:0] pcount,
  output logic [1:0] dcount,
`ifdef HAND_SCORE_EN
  output logic [3:0] pscore,
  output logic [3:0] dscore,
`endif
  output logic [1:0] dbg_state
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_WRITE = 2'd1;
  localparam logic [1:0] S_ACK   = 2'd2;

  logic [1:0] r_state;
  logic [3:0] r_ctr;
  logic [3:0] r_sample;
  logic       r_tgt;
  logic       r_ovf;
  logic [3:0] r_pcard [0:2];
  logic [3:0] r_dcard [0:2];
  logic [1:0] r_pcount;
  logic [1:0] r_dcount;

`ifdef HAND_SCORE_EN
  logic [3:0] r_pscore;
  logic [3:0] r_dscore;
  logic [3:0] w_face;
  logic [4:0] w_psum;
  logic [4:0] w_dsum;
  logic [3:0] w_pscore_nxt;
  logic [3:0] w_dscore_nxt;

  // Face values 10..15 (and 0) contribute nothing to the Baccarat total.
  assign w_face       = (r_sample >= 4'd1 && r_sample <= 4'd9) ? r_sample : 4'd0;
  assign w_psum       = {1'b0, r_pscore} + {1'b0, w_face};
  assign w_dsum       = {1'b0, r_dscore} + {1'b0, w_face};
  assign w_pscore_nxt = (w_psum >= 5'd10) ? 4'(w_psum - 5'd10) : w_psum[3:0];
  assign w_dscore_nxt = (w_dsum >= 5'd10) ? 4'(w_dsum - 5'd10) : w_dsum[3:0];
  assign pscore       = r_pscore;
  assign dscore       = r_dscore;
`endif

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state  <= S_IDLE;
      r_ctr    <= 4'd1;
      r_sample <= 4'd0;
      r_tgt    <= 1'b0;
      r_ovf    <= 1'b0;
      r_pcount <= 2'd0;
      r_dcount <= 2'd0;
      for (int i = 0; i < 3; i++) begin
        r_pcard[i] <= 4'd0;
        r_dcard[i] <= 4'd0;
      end
`ifdef HAND_SCORE_EN
      r_pscore <= 4'd0;
      r_dscore <= 4'd0;
`endif
    end else begin
      // The counter never holds; its value before the accept edge is the card.
      r_ctr <= (r_ctr >= 4'(DECK_MAX)) ? 4'd1 : r_ctr + 4'd1;
      case (r_state)
        S_IDLE: begin
          if (clear) begin
            r_ovf    <= 1'b0;
            r_pcount <= 2'd0;
            r_dcount <= 2'd0;
            for (int i = 0; i < 3; i++) begin
              r_pcard[i] <= 4'd0;
              r_dcard[i] <= 4'd0;
            end
`ifdef HAND_SCORE_EN
            r_pscore <= 4'd0;
            r_dscore <= 4'd0;
`endif
          end else if (deal_req) begin
            r_sample <= r_ctr;
            r_tgt    <= target;
            r_state  <= S_WRITE;
          end
        end
        S_WRITE: begin
          if (!r_tgt) begin
            if (r_pcount != 2'd3) begin
              r_pcard[r_pcount] <= r_sample;
              r_pcount          <= r_pcount + 2'd1;
`ifdef HAND_SCORE_EN
              r_pscore          <= w_pscore_nxt;
`endif
            end else begin
              r_ovf <= 1'b1;
            end
          end else begin
            if (r_dcount != 2'd3) begin
              r_dcard[r_dcount] <= r_sample;
              r_dcount          <= r_dcount + 2'd1;
`ifdef HAND_SCORE_EN
              r_dscore          <= w_dscore_nxt;
`endif
            end else begin
              r_ovf <= 1'b1;
            end
          end
          r_state <= S_ACK;
        end
        S_ACK:   r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign busy      = (r_state == S_WRITE) || (r_state == S_ACK);
  assign done      = (r_state == S_ACK);
  assign overflow  = r_ovf;
  assign pcard1    = r_pcard[0];
  assign pcard2    = r_pcard[1];
  assign pcard3    = r_pcard[2];
  assign dcard1    = r_dcard[0];
  assign dcard2    = r_dcard[1];
  assign dcard3    = r_dcard[2];
  assign pcount    = r_pcount;
  assign dcount    = r_dcount;
  assign dbg_state = r_state;

endmodule

// File: tb/tb_hand_dealer.sv
// Randomized bench for hand_dealer against a cycle-level model of the dealing
// rules (card = edge index mod deck + 1). Checks scores when HAND_SCORE_EN is set.
module tb_hand_dealer;

  localparam int DM = 13;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       deal_req = 1'b0;
  logic       target = 1'b0;
  logic       clear = 1'b0;
  logic       busy, done, overflow;
  logic [3:0] pcard1, pcard2, pcard3, dcard1, dcard2, dcard3;
  logic [1:0] pcount, dcount, dbg_state;
`ifdef HAND_SCORE_EN
  logic [3:0] pscore, dscore;
`endif

  hand_dealer #(.DECK_MAX(DM)) dut (
    .clock(clock), .reset(reset), .deal_req(deal_req), .target(target),
    .clear(clear), .busy(busy), .done(done), .overflow(overflow),
    .pcard1(pcard1), .pcard2(pcard2), .pcard3(pcard3),
    .dcard1(dcard1), .dcard2(dcard2), .dcard3(dcard3),
    .pcount(pcount), .dcount(dcount),
`ifdef HAND_SCORE_EN
    .pscore(pscore), .dscore(dscore),
`endif
    .dbg_state(dbg_state)
  );

  // clock / reset
  always #5 clock = ~clock;

  int total = 0;
  int bad   = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Reference model: hands as queues, edges counted since reset release.
  int         m_k;
  int         m_phase;      // cycles since accept: 0 = free, 1 = writing, 2 = acknowledging
  logic [3:0] m_card;
  logic       m_tgt;
  logic       m_ovf;
  logic [3:0] m_ph[$];
  logic [3:0] m_dh[$];
  logic [4:0] exp_q[$];     // {target, card} of cards expected to appear

  function automatic int face(input logic [3:0] v);
    return (v >= 1 && v <= 9) ? int'(v) : 0;
  endfunction

  function automatic int score(input logic [3:0] h[$]);
    int s = 0;
    foreach (h[i]) s += face(h[i]);
    return s % 10;
  endfunction

  function automatic logic [3:0] slot(input logic [3:0] h[$], input int i);
    return (i < h.size()) ? h[i] : 4'd0;
  endfunction

  task automatic model_reset();
    m_k = 0; m_phase = 0; m_ovf = 1'b0;
    m_ph.delete(); m_dh.delete(); exp_q.delete();
  endtask

  task automatic model_edge();
    if (reset) begin
      model_reset();
      return;
    end
    if (m_phase == 0) begin
      if (clear) begin
        m_ph.delete(); m_dh.delete(); m_ovf = 1'b0;
      end else if (deal_req) begin
        m_card  = 4'((m_k % DM) + 1);
        m_tgt   = target;
        m_phase = 1;
      end
    end else if (m_phase == 1) begin
      if (!m_tgt) begin
        if (m_ph.size() < 3) begin m_ph.push_back(m_card); exp_q.push_back({1'b0, m_card}); end
        else m_ovf = 1'b1;
      end else begin
        if (m_dh.size() < 3) begin m_dh.push_back(m_card); exp_q.push_back({1'b1, m_card}); end
        else m_ovf = 1'b1;
      end
      m_phase = 2;
    end else begin
      m_phase = 0;
    end
    m_k++;
  endtask

  task automatic compare_all();
    logic [4:0] e;
    check("busy", busy, m_phase != 0);
    check("done", done, m_phase == 2);
    check("overflow", overflow, m_ovf);
    check("pcount", pcount, m_ph.size());
    check("dcount", dcount, m_dh.size());
    check("pcard1", pcard1, slot(m_ph, 0));
    check("pcard2", pcard2, slot(m_ph, 1));
    check("pcard3", pcard3, slot(m_ph, 2));
    check("dcard1", dcard1, slot(m_dh, 0));
    check("dcard2", dcard2, slot(m_dh, 1));
    check("dcard3", dcard3, slot(m_dh, 2));
`ifdef HAND_SCORE_EN
    check("pscore", pscore, score(m_ph));
    check("dscore", dscore, score(m_dh));
`endif
    // scoreboard: a freshly written card must sit in the newest slot
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      if (!e[4]) check("sb_new_pcard", (pcount == 2'd0) ? 4'd0 : (pcount == 2'd1 ? pcard1 : (pcount == 2'd2 ? pcard2 : pcard3)), e[3:0]);
      else       check("sb_new_dcard", (dcount == 2'd0) ? 4'd0 : (dcount == 2'd1 ? dcard1 : (dcount == 2'd2 ? dcard2 : dcard3)), e[3:0]);
    end
  endtask

  // driver tasks
  task automatic tick();
    @(posedge clock);
    model_edge();
    #1;
    compare_all();
  endtask

  task automatic do_reset();
    reset = 1'b1; deal_req = 1'b0; clear = 1'b0; target = 1'b0;
    tick(); tick();
    reset = 1'b0;
    model_reset();
  endtask

  task automatic deal(input logic t);
    deal_req = 1'b1; target = t;
    tick();
    deal_req = 1'b0;
    tick(); tick();
  endtask

  int dones;

  initial begin
    model_reset();
    do_reset();
    check("rst_busy", busy, 1'b0);
    check("rst_done", done, 1'b0);
    check("rst_pcount", pcount, 2'd0);

    // counter wraps back to 1 after DM idle edges
    repeat (DM) tick();
    deal_req = 1'b1; target = 1'b0;
    tick();
    deal_req = 1'b0;
    dones = 0;
    repeat (4) begin tick(); if (done) dones++; end
    check("wrap_pcard1", pcard1, 4'd1);
    check("wrap_pcount", pcount, 2'd1);
    check("wrap_done_once", dones, 1);

    // held request deals every third edge: 1, 4, 7
    do_reset();
    deal_req = 1'b1; target = 1'b0;
    repeat (9) tick();
    deal_req = 1'b0;
    check("held_pcard1", pcard1, 4'd1);
    check("held_pcard2", pcard2, 4'd4);
    check("held_pcard3", pcard3, 4'd7);
`ifdef HAND_SCORE_EN
    check("held_pscore", pscore, 4'd2);
`endif

    // overflow then clear
    deal(1'b0);
    check("ovf_flag", overflow, 1'b1);
    check("ovf_pcount", pcount, 2'd3);
    check("ovf_pcard3", pcard3, 4'd7);
    clear = 1'b1; tick(); clear = 1'b0; tick();
    check("clr_ovf", overflow, 1'b0);
    check("clr_pcount", pcount, 2'd0);
    check("clr_pcard1", pcard1, 4'd0);

    // dealer routing: steer the first dealer card to 11
    while (((m_k % DM) + 1) != 11) tick();
    deal(1'b1);
    check("dlr_dcard1", dcard1, 4'd11);
    check("dlr_pcard1", pcard1, 4'd0);
`ifdef HAND_SCORE_EN
    check("dlr_dscore", dscore, 4'd0);
`endif
    repeat (2) begin
      repeat ($urandom_range(0, 12)) tick();
      deal(1'b1);
    end
    check("dlr_dcount", dcount, 2'd3);
    check("dlr_pcount", pcount, 2'd0);

    // clear beats deal_req in the same IDLE cycle
    clear = 1'b1; deal_req = 1'b1; tick();
    clear = 1'b0; deal_req = 1'b0; tick();
    check("prio_busy", busy, 1'b0);
    check("prio_dcount", dcount, 2'd0);

    // clear during WRITE is ignored
    deal_req = 1'b1; target = 1'b0; tick();
    deal_req = 1'b0; clear = 1'b1; tick();
    clear = 1'b0; tick(); tick();
    check("wclr_pcount", pcount, 2'd1);

    // reset asserted in WRITE returns everything immediately
    deal_req = 1'b1; target = 1'b1; tick();
    deal_req = 1'b0;
    check("mid_state_write", dbg_state, 2'd1);
    reset = 1'b1; #1;
    model_reset();
    compare_all();
    tick();
    reset = 1'b0;
    model_reset();
    dones = 0;
    repeat (4) begin tick(); if (done) dones++; end
    check("mid_no_done", dones, 0);
    check("mid_dcount", dcount, 2'd0);

    // random traffic
    repeat (300) begin
      deal_req = 1'($urandom_range(0, 1));
      target   = 1'($urandom_range(0, 1));
      clear    = ($urandom_range(0, 11) == 0);
      tick();
    end
    deal_req = 1'b0; clear = 1'b0;
    repeat (3) tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end

endmodule
